// File: rtl/uart_alu_interface_if.sv
// uart_alu_interface_if: UART-side strobes/bytes and ALU operand/result bus for uart_alu_interface
interface uart_alu_interface_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic                  i_rx_done_bit;
  logic [DATA_WIDTH-1:0] i_rx_data_byte;
  logic                  i_tx_done_bit;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic [DATA_WIDTH-1:0] o_data_a;
  logic [DATA_WIDTH-1:0] o_data_b;
  logic [OP_WIDTH-1:0]   o_op;
  logic [DATA_WIDTH-1:0] o_tx_data_byte;
  logic                  o_tx_signal;
  logic                  o_busy;
  modport slave (
    input  i_rx_done_bit, i_rx_data_byte, i_tx_done_bit, i_alu_result,
    output o_data_a, o_data_b, o_op, o_tx_data_byte, o_tx_signal, o_busy
  );
  modport master (
    output i_rx_done_bit, i_rx_data_byte, i_tx_done_bit, i_alu_result,
    input  o_data_a, o_data_b, o_op, o_tx_data_byte, o_tx_signal, o_busy
  );
endinterface

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects A, B, opcode bytes from the UART, latches the ALU result and starts a transmit.
// Optional inter-byte timeout enabled by defining UART_IF_TIMEOUT_EN.
module uart_alu_interface #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic clk,
  input logic reset,
  uart_alu_interface_if.slave bus
);
  if (OP_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_alu_interface: invalid OP_WIDTH or TIMEOUT_CYCLES");
  end
  typedef enum logic [2:0] {S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_CALC, S_SEND, S_WAIT_TX} state_t;
  state_t state, next;
  logic rx_d, tx_d, rx_evt, tx_evt, tmo;
  assign rx_evt = bus.i_rx_done_bit & ~rx_d;
  assign tx_evt = bus.i_tx_done_bit & ~tx_d;
`ifdef UART_IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset || rx_evt || !(state inside {S_WAIT_B, S_WAIT_OP})) cnt <= '0;
    else cnt <= cnt + 1'b1;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      S_WAIT_A:  next = rx_evt ? S_WAIT_B : S_WAIT_A;
      S_WAIT_B:  next = rx_evt ? S_WAIT_OP : tmo ? S_WAIT_A : S_WAIT_B;
      S_WAIT_OP: next = rx_evt ? S_CALC : tmo ? S_WAIT_A : S_WAIT_OP;
      S_CALC:    next = S_SEND;
      S_SEND:    next = S_WAIT_TX;
      S_WAIT_TX: next = tx_evt ? S_WAIT_A : S_WAIT_TX;
      default:   next = S_WAIT_A;
    endcase
  end
  assign bus.o_tx_signal = state == S_SEND;
  assign bus.o_busy      = state != S_WAIT_A;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= S_WAIT_A;
      rx_d               <= 1'b0;
      tx_d               <= 1'b0;
      bus.o_data_a       <= '0;
      bus.o_data_b       <= '0;
      bus.o_op           <= '0;
      bus.o_tx_data_byte <= '0;
    end else begin
      state <= next;
      rx_d  <= bus.i_rx_done_bit;
      tx_d  <= bus.i_tx_done_bit;
      if (state == S_WAIT_A && rx_evt) bus.o_data_a <= bus.i_rx_data_byte;
      if (state == S_WAIT_B && rx_evt) bus.o_data_b <= bus.i_rx_data_byte;
      if (state == S_WAIT_OP && rx_evt) bus.o_op <= bus.i_rx_data_byte[OP_WIDTH-1:0];
      if (state == S_CALC) bus.o_tx_data_byte <= bus.i_alu_result;
    end
  end
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: directed vector table plus hand sequences for strobes, drops, reset and timeout.
module tb_uart_alu_interface;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int errors = 0;
  int pulses = 0;
  uart_alu_interface_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();
  uart_alu_interface #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.i_alu_result = bus.o_op == 6'h20 ? bus.o_data_a + bus.o_data_b :
                            bus.o_op == 6'h22 ? bus.o_data_a - bus.o_data_b :
                            bus.o_data_a ^ bus.o_data_b;
  always @(posedge clk) if (bus.o_tx_signal) pulses <= pulses + 1;
  typedef struct {
    logic [7:0] a, b, opb, exp_op, exp_tx;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rx_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.i_rx_data_byte = b;
    bus.i_rx_done_bit = 1'b1;
    repeat (hold) @(negedge clk);
    bus.i_rx_done_bit = 1'b0;
  endtask
  task automatic tx_done();
    @(negedge clk);
    bus.i_tx_done_bit = 1'b1;
    @(negedge clk);
    bus.i_tx_done_bit = 1'b0;
  endtask
  task automatic finish_cmd(input string name, input logic [7:0] exp_tx);
    int p0;
    p0 = pulses;
    chk({name, " calc_no_pulse"}, 8'(bus.o_tx_signal), 8'h00);
    @(negedge clk);
    chk({name, " pulse"}, 8'(bus.o_tx_signal), 8'h01);
    @(negedge clk);
    chk({name, " pulse_end"}, 8'(bus.o_tx_signal), 8'h00);
    chk({name, " pulse_count"}, 8'(pulses - p0), 8'h01);
    chk({name, " tx_byte"}, bus.o_tx_data_byte, exp_tx);
    chk({name, " busy_tx"}, 8'(bus.o_busy), 8'h01);
  endtask
  initial begin
    int p0;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h20, 8'h08};
    vecs[1] = '{8'h03, 8'h05, 8'h22, 8'h22, 8'hFE};
    vecs[2] = '{8'hFF, 8'h01, 8'h20, 8'h20, 8'h00};
    vecs[3] = '{8'h10, 8'h01, 8'h22, 8'h22, 8'h0F};
    vecs[4] = '{8'h07, 8'h08, 8'hE0, 8'h20, 8'h0F};
    vecs[5] = '{8'h3C, 8'h0F, 8'hC5, 8'h05, 8'h33};
    bus.i_rx_done_bit = 1'b0;
    bus.i_rx_data_byte = 8'h00;
    bus.i_tx_done_bit = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("rst data_a", bus.o_data_a, 8'h00);
    chk("rst data_b", bus.o_data_b, 8'h00);
    chk("rst op", 8'(bus.o_op), 8'h00);
    chk("rst tx_byte", bus.o_tx_data_byte, 8'h00);
    chk("rst tx_signal", 8'(bus.o_tx_signal), 8'h00);
    chk("rst busy", 8'(bus.o_busy), 8'h00);
    for (int i = 0; i < 6; i++) begin
      rx_byte(vecs[i].a, 1);
      chk($sformatf("v%0d busy_b", i), 8'(bus.o_busy), 8'h01);
      rx_byte(vecs[i].b, 1);
      rx_byte(vecs[i].opb, 1);
      chk($sformatf("v%0d data_a", i), bus.o_data_a, vecs[i].a);
      chk($sformatf("v%0d data_b", i), bus.o_data_b, vecs[i].b);
      chk($sformatf("v%0d op", i), 8'(bus.o_op), vecs[i].exp_op);
      finish_cmd($sformatf("v%0d", i), vecs[i].exp_tx);
      tx_done();
      chk($sformatf("v%0d idle", i), 8'(bus.o_busy), 8'h00);
      chk($sformatf("v%0d hold_a", i), bus.o_data_a, vecs[i].a);
    end
    rx_byte(8'hAA, 5);
    chk("held data_a", bus.o_data_a, 8'hAA);
    chk("held data_b_kept", bus.o_data_b, 8'h0F);
    rx_byte(8'h01, 1);
    rx_byte(8'h20, 1);
    chk("held data_b", bus.o_data_b, 8'h01);
    chk("held op", 8'(bus.o_op), 8'h20);
    finish_cmd("held", 8'hAB);
    tx_done();
    rx_byte(8'h21, 1);
    rx_byte(8'h10, 1);
    rx_byte(8'h22, 1);
    finish_cmd("drop", 8'h11);
    p0 = pulses;
    rx_byte(8'h77, 1);
    repeat (3) @(negedge clk);
    chk("drop data_a", bus.o_data_a, 8'h21);
    chk("drop data_b", bus.o_data_b, 8'h10);
    chk("drop op", 8'(bus.o_op), 8'h22);
    chk("drop tx_byte", bus.o_tx_data_byte, 8'h11);
    chk("drop busy", 8'(bus.o_busy), 8'h01);
    chk("drop no_pulse", 8'(pulses - p0), 8'h00);
    tx_done();
    chk("drop idle", 8'(bus.o_busy), 8'h00);
    rx_byte(8'h11, 1);
    chk("after_drop data_a", bus.o_data_a, 8'h11);
    tx_done();
    chk("tx_in_b ignored", 8'(bus.o_busy), 8'h01);
    rx_byte(8'h01, 1);
    rx_byte(8'h20, 1);
    finish_cmd("after_drop", 8'h12);
    @(negedge clk);
    bus.i_rx_data_byte = 8'h55;
    bus.i_rx_done_bit = 1'b1;
    bus.i_tx_done_bit = 1'b1;
    @(negedge clk);
    bus.i_rx_done_bit = 1'b0;
    bus.i_tx_done_bit = 1'b0;
    chk("both idle", 8'(bus.o_busy), 8'h00);
    chk("both data_a", bus.o_data_a, 8'h11);
    tx_done();
    chk("tx_in_a ignored", 8'(bus.o_busy), 8'h00);
    rx_byte(8'h12, 1);
    rx_byte(8'h34, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst data_a", bus.o_data_a, 8'h00);
    chk("mid_rst data_b", bus.o_data_b, 8'h00);
    chk("mid_rst op", 8'(bus.o_op), 8'h00);
    chk("mid_rst tx_byte", bus.o_tx_data_byte, 8'h00);
    chk("mid_rst busy", 8'(bus.o_busy), 8'h00);
    rx_byte(8'h01, 1);
    rx_byte(8'h02, 1);
    rx_byte(8'h20, 1);
    finish_cmd("post_rst", 8'h03);
    tx_done();
    p0 = pulses;
    rx_byte(8'h09, 1);
`ifdef UART_IF_TIMEOUT_EN
    repeat (49) @(negedge clk);
    chk("tmo not_yet", 8'(bus.o_busy), 8'h01);
    @(negedge clk);
    chk("tmo idle", 8'(bus.o_busy), 8'h00);
    chk("tmo no_pulse", 8'(pulses - p0), 8'h00);
    chk("tmo data_a_kept", bus.o_data_a, 8'h09);
    rx_byte(8'h04, 1);
    chk("tmo next data_a", bus.o_data_a, 8'h04);
    chk("tmo next busy", 8'(bus.o_busy), 8'h01);
`else
    repeat (60) @(negedge clk);
    chk("no_tmo busy", 8'(bus.o_busy), 8'h01);
    chk("no_tmo no_pulse", 8'(pulses - p0), 8'h00);
    rx_byte(8'h02, 1);
    rx_byte(8'h20, 1);
    finish_cmd("no_tmo", 8'h0B);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Parallel-side peer of the UART receiver/transmitter pair. Sits between the UART and an external ALU.
- Assembles three received bytes into operand A, operand B and opcode, in that order.
- Presents these to the ALU, captures the ALU result and hands it to the UART transmitter.
- Waits for transmit completion before accepting the next command.

Parameters:
- DATA_WIDTH, 8, width of UART data bytes, operands and result
- OP_WIDTH, 6, width of the opcode field; the low OP_WIDTH bits of the opcode byte are used (OP_WIDTH <= DATA_WIDTH)
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles; only used with UART_IF_TIMEOUT_EN

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- i_rx_done_bit  input  1  receiver byte-complete strobe, high for >=1 cycle per byte
- i_rx_data_byte  input  DATA_WIDTH  received byte, valid while i_rx_done_bit is high
- i_tx_done_bit  input  1  transmitter frame-complete strobe, high for >=1 cycle
- i_alu_result  input  DATA_WIDTH  combinational ALU result for o_data_a/o_data_b/o_op
- o_data_a  output  DATA_WIDTH  operand A register
- o_data_b  output  DATA_WIDTH  operand B register
- o_op  output  OP_WIDTH  opcode register
- o_tx_data_byte  output  DATA_WIDTH  byte to transmit
- o_tx_signal  output  1  transmit start, exactly 1-cycle pulse
- o_busy  output  1  high in any state other than S_WAIT_A

Behaviour:
- Sampling: all state updates occur on rising clk; reset is checked synchronously (reset==0).
- Reset values: o_data_a=0, o_data_b=0, o_op=0, o_tx_data_byte=0, o_tx_signal=0, o_busy=0. State=S_WAIT_A. Both edge-detect registers=0.
- Edge detect: rx_evt = i_rx_done_bit & ~rx_d (registered previous value); tx_evt is formed the same way. A strobe held high for several cycles counts as one event.
- FSM states and transitions:
  - S_WAIT_A: on rx_evt, o_data_a <= i_rx_data_byte; go to S_WAIT_B.
  - S_WAIT_B: on rx_evt, o_data_b <= i_rx_data_byte; go to S_WAIT_OP.
  - S_WAIT_OP: on rx_evt, o_op <= i_rx_data_byte[OP_WIDTH-1:0]; go to S_CALC.
  - S_CALC: one cycle, letting the ALU settle on the new registers. o_tx_data_byte <= i_alu_result; go to S_SEND.
  - S_SEND: o_tx_signal=1 for this single cycle; go to S_WAIT_TX.
  - S_WAIT_TX: on tx_evt, go to S_WAIT_A.
- Latency: the o_tx_signal pulse occurs exactly 2 cycles after the cycle in which rx_evt is registered for the opcode byte.
- Registers hold their values between commands. o_data_a, o_data_b and o_op remain driven after transmission completes.
- rx_evt in S_CALC, S_SEND or S_WAIT_TX is dropped with no side effects; the byte is lost.
- tx_evt in any state other than S_WAIT_TX is ignored.
- rx_evt and tx_evt in the same cycle in S_WAIT_TX: return to S_WAIT_A; the rx byte is dropped.
- Reset asserted mid-command (any state): the next clk restores all reset values; any partial command is discarded.
- Unreachable state encodings go to S_WAIT_A.

Optional Feature:
- Macro: UART_IF_TIMEOUT_EN.
- Defined:
  - A counter runs while in S_WAIT_B or S_WAIT_OP and clears on every rx_evt.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_evt, the FSM returns to S_WAIT_A. Operand and opcode registers keep their last values; nothing is transmitted.
  - The counter clears on entering S_WAIT_A.
- Undefined: no counter exists; the FSM waits indefinitely between bytes.

Test Plan:
- Basic ADD: rx bytes 0x05, 0x03, 0x20 with the ALU model returning a+b. Required: o_data_a=0x05, o_data_b=0x03, o_op=0x20, o_tx_data_byte=0x08, a single o_tx_signal pulse 2 cycles after the third rx_evt. Then tx_evt returns the FSM to S_WAIT_A with o_busy=0.
- Held strobe: i_rx_done_bit held high for 5 cycles with byte 0xAA. Required: only o_data_a=0xAA is captured and the state is S_WAIT_B, not S_WAIT_OP.
- Byte during transmit: send a full command, then inject rx byte 0x77 in S_WAIT_TX. Required: 0x77 is dropped, the registers are unchanged, and after tx_evt the next byte 0x11 loads o_data_a.
- Reset mid-command: after rx bytes 0x12, 0x34, drive reset=0 for 1 cycle. Required: all outputs are 0 and the state is S_WAIT_A; a new 3-byte command 0x01, 0x02, 0x20 produces tx byte 0x03.
- SUB wrap-around: 0x03, 0x05, 0x22 with the ALU returning a-b. Required: o_tx_data_byte=0xFE.
- Timeout (macro defined, TIMEOUT_CYCLES=50): rx 0x09, then idle for 50 cycles. Required: return to S_WAIT_A, no o_tx_signal, and the next byte 0x04 loads o_data_a.
